// File: rtl/booth_seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : booth_seq_multiplier
//  Description : Iterative radix-4 Booth multiplier with valid/ready
//                handshakes on the operand and result sides. One product
//                every WIDTH/2+1 RUN cycles; the full 2*WIDTH-bit result is
//                exact for every operand pair.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH        operand width (even, >= 4)
//  Ports
//    clk          clock, rising edge
//    rst          synchronous reset, active low
//    in_valid     operands X, Y (and signed_mode) valid
//    in_ready     block can accept operands (state IDLE)
//    signed_mode  1: two's complement, 0: unsigned
//                 (only with BOOTH_SEQ_MULT_SIGNED_MODE_EN)
//    X, Y         multiplicand, multiplier
//    out_valid    Z holds a finished product (state DONE)
//    out_ready    consumer accepts Z
//    Z            registered product, 2*WIDTH bits
//    busy         state is not IDLE
//  Build option
//    BOOTH_SEQ_MULT_SIGNED_MODE_EN : adds the runtime signed_mode port.
//    Without it operands are always two's complement.
// ============================================================================
module booth_seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
`ifdef BOOTH_SEQ_MULT_SIGNED_MODE_EN
    input  logic                 signed_mode,
`endif
    input  logic [WIDTH-1:0]     X,
    input  logic [WIDTH-1:0]     Y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   Z,
    output logic                 busy
);

    // Extended operand width and Booth iteration count
    localparam int c_EW    = WIDTH + 2;
    localparam int c_ITERS = WIDTH / 2 + 1;
    localparam int c_CW    = $clog2(c_ITERS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [c_EW-1:0]     r_m;      // extended multiplicand
    logic [c_EW-1:0]     r_acc;    // upper half of the product register
    logic [c_EW:0]       r_q;      // lower half plus the Booth guard bit at [0]
    logic [c_CW-1:0]     r_cnt;

    logic                w_sext;
    logic [c_EW-1:0]     w_x_ext;
    logic [c_EW-1:0]     w_y_ext;
    logic [c_EW+1:0]     w_m_wide;
    logic [c_EW+1:0]     w_acc_wide;
    logic [c_EW+1:0]     w_pp;
    logic [c_EW+1:0]     w_sum;
    logic                w_last;

`ifdef BOOTH_SEQ_MULT_SIGNED_MODE_EN
    assign w_sext = signed_mode;
`else
    assign w_sext = 1'b1;
`endif

    assign w_x_ext = {{2{w_sext & X[WIDTH-1]}}, X};
    assign w_y_ext = {{2{w_sext & Y[WIDTH-1]}}, Y};

    // Two guard bits on the adder: acc + 2M can exceed the W+2-bit range
    // before the shift brings it back.
    assign w_m_wide   = {{2{r_m[c_EW-1]}}, r_m};
    assign w_acc_wide = {{2{r_acc[c_EW-1]}}, r_acc};

    always_comb begin
        w_pp = '0;
        unique case (r_q[2:0])
            3'b001, 3'b010: w_pp = w_m_wide;
            3'b011:         w_pp = {w_m_wide[c_EW:0], 1'b0};
            3'b100:         w_pp = -{w_m_wide[c_EW:0], 1'b0};
            3'b101, 3'b110: w_pp = -w_m_wide;
            default:        w_pp = '0;
        endcase
    end

    assign w_sum  = w_acc_wide + w_pp;
    assign w_last = (r_cnt == c_CW'(c_ITERS - 1));

    // ------------------------------------------------------------------
    // Control state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: add the Booth digit into the upper half, then shift the
    // whole {acc, q} register right arithmetically by two.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_m   <= '0;
            r_acc <= '0;
            r_q   <= '0;
            r_cnt <= '0;
            Z     <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_m   <= w_x_ext;
                        r_q   <= {w_y_ext, 1'b0};
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                S_RUN: begin
                    r_acc <= w_sum[c_EW+1:2];
                    r_q   <= {w_sum[1:0], r_q[c_EW:2]};
                    r_cnt <= r_cnt + c_CW'(1);
                    // Low 2*WIDTH bits of the post-shift product register
                    if (w_last) begin
                        Z <= {w_sum[WIDTH-1:0], r_q[c_EW:3]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
